// File: rtl/hist_portb_scheduler.sv
// Histogram RAM port B owner: clears all banks after reset, then per frame
// reads every bank out in order and clears it again before the next frame.
module hist_portb_scheduler #(
  parameter int BINS   = 256,
  parameter int ADDR_W = 8,
  parameter int BANKS  = 32,
  parameter int BANK_W = 5,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_done,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] portb_q,
  output logic [ADDR_W-1:0] portb_addr,
  output logic [DATA_W-1:0] portb_din,
  output logic [BANKS-1:0]  portb_wren_bus,
  output logic              portb_rd_en,
  output logic [BANK_W-1:0] portb_bank_sel,
  output logic              bin_valid,
  output logic [DATA_W-1:0] bin_data,
  output logic [BANK_W-1:0] bin_bank,
  output logic [ADDR_W-1:0] bin_addr,
  output logic              init_done,
  output logic              busy,
  output logic              sched_done,
  output logic              overrun
);

  localparam logic [2:0] S_INIT_CLR = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_CLR      = 3'd4;

  localparam int DR_W = $clog2(RD_LAT + 2);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [BANK_W-1:0] r_bank;
  logic [DR_W-1:0]   r_drain;
  logic              r_armed;
  logic              r_init_done;
  logic              r_sched_done;
  logic              r_overrun;

  logic              r_pv [RD_LAT];
  logic [BANK_W-1:0] r_pb [RD_LAT];
  logic [ADDR_W-1:0] r_pa [RD_LAT];

  logic              r_bin_valid;
  logic [DATA_W-1:0] r_bin_data;
  logic [BANK_W-1:0] r_bin_bank;
  logic [ADDR_W-1:0] r_bin_addr;

  logic w_wait;
  logic w_issue;
  logic w_clr;
  logic w_last_addr;
  logic w_last_bank;
  logic w_drain_end;

  assign w_wait      = (r_state == S_WAIT);
  assign w_issue     = (r_state == S_READ) && rd_ready;
  assign w_last_addr = (r_addr == ADDR_W'(BINS - 1));
  assign w_last_bank = (r_bank == BANK_W'(BANKS - 1));
  assign w_drain_end = (r_drain == DR_W'(RD_LAT));

  // INIT_CLR holds off one cycle after release so reset outputs stay quiet
  assign w_clr = ((r_state == S_INIT_CLR) && r_armed)
              || (r_state == S_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_INIT_CLR;
      r_addr       <= '0;
      r_bank       <= '0;
      r_drain      <= '0;
      r_armed      <= 1'b0;
      r_init_done  <= 1'b0;
      r_sched_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sched_done <= 1'b0;
      if (frame_done && !w_wait) begin
        r_overrun <= 1'b1;
      end
      unique case (1'b1)
        (r_state == S_INIT_CLR): begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (w_last_addr) begin
            r_addr      <= '0;
            r_state     <= S_WAIT;
            r_init_done <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        (r_state == S_WAIT): begin
          if (frame_done) begin
            r_state <= S_READ;
            r_addr  <= '0;
            r_bank  <= '0;
          end
        end
        (r_state == S_READ): begin
          if (rd_ready) begin
            if (w_last_addr) begin
              r_addr <= '0;
              if (w_last_bank) begin
                r_bank  <= '0;
                r_drain <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_bank <= r_bank + 1'b1;
              end
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        (r_state == S_DRAIN): begin
          if (w_drain_end) begin
            r_drain <= '0;
            r_addr  <= '0;
            r_state <= S_CLR;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        (r_state == S_CLR): begin
          if (w_last_addr) begin
            r_addr       <= '0;
            r_state      <= S_WAIT;
            r_sched_done <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_INIT_CLR;
          r_addr  <= '0;
          r_bank  <= '0;
        end
      endcase
    end
  end

  // Issue tags ride alongside the RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pb[i] <= '0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_issue;
      r_pb[0] <= r_bank;
      r_pa[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pb[i] <= r_pb[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_valid <= 1'b0;
      r_bin_data  <= '0;
      r_bin_bank  <= '0;
      r_bin_addr  <= '0;
    end else begin
      r_bin_valid <= r_pv[RD_LAT-1];
      if (r_pv[RD_LAT-1]) begin
        r_bin_data <= portb_q;
        r_bin_bank <= r_pb[RD_LAT-1];
        r_bin_addr <= r_pa[RD_LAT-1];
      end
    end
  end

  assign portb_addr     = r_addr;
  assign portb_din      = '0;
  assign portb_wren_bus = {BANKS{w_clr}};
  assign portb_rd_en    = w_issue;
  assign portb_bank_sel = r_bank;
  assign bin_valid      = r_bin_valid;
  assign bin_data       = r_bin_data;
  assign bin_bank       = r_bin_bank;
  assign bin_addr       = r_bin_addr;
  assign init_done      = r_init_done;
  assign busy           = !w_wait;
  assign sched_done     = r_sched_done;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_hist_portb_scheduler.sv
// Bench for hist_portb_scheduler: behavioural port-B RAM, scenario table
// for frame read-out, hand sequences for reset init-clear and mid-clear reset.
module tb_hist_portb_scheduler;

  localparam int BINS   = 256;
  localparam int BANKS  = 32;
  localparam int RD_LAT = 2;
  localparam int TOTAL  = BINS * BANKS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_done;
  logic        rd_ready;
  logic [15:0] portb_q;
  logic [7:0]  portb_addr;
  logic [15:0] portb_din;
  logic [31:0] portb_wren_bus;
  logic        portb_rd_en;
  logic [4:0]  portb_bank_sel;
  logic        bin_valid;
  logic [15:0] bin_data;
  logic [4:0]  bin_bank;
  logic [7:0]  bin_addr;
  logic        init_done;
  logic        busy;
  logic        sched_done;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hist_portb_scheduler #(
    .BINS(BINS), .ADDR_W(8), .BANKS(BANKS),
    .BANK_W(5), .DATA_W(16), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_done(frame_done), .rd_ready(rd_ready),
    .portb_q(portb_q), .portb_addr(portb_addr),
    .portb_din(portb_din), .portb_wren_bus(portb_wren_bus),
    .portb_rd_en(portb_rd_en), .portb_bank_sel(portb_bank_sel),
    .bin_valid(bin_valid), .bin_data(bin_data),
    .bin_bank(bin_bank), .bin_addr(bin_addr),
    .init_done(init_done), .busy(busy),
    .sched_done(sched_done), .overrun(overrun)
  );

  // Port-B RAM model: all banks share address, read data muxed by bank_sel
  logic [15:0] mem [BANKS][BINS];
  logic [15:0] qp [RD_LAT];
  logic        do_fill = 1'b0;

  always @(posedge clk) begin
    if (do_fill)
      for (int b = 0; b < BANKS; b++)
        for (int a = 0; a < BINS; a++)
          mem[b][a] <= 16'(b * BINS + a);
    for (int b = 0; b < BANKS; b++)
      if (portb_wren_bus[b]) mem[b][portb_addr] <= portb_din;
    qp[0] <= portb_rd_en ? mem[portb_bank_sel][portb_addr] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end

  assign portb_q = qp[RD_LAT-1];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int mem_nz();
    int n = 0;
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a < BINS; a++)
        if (mem[b][a] !== 16'd0) n++;
    return n;
  endfunction

  // Entered with rst_n low; checks reset outputs then the init clear
  task automatic init_check(input string tag);
    int wr = 0;
    int seq = 0;
    int bad = 0;
    int cyc = 0;
    #1;
    chk({tag, "_rst_wren"}, portb_wren_bus, 0);
    chk({tag, "_rst_busy"}, busy, 1);
    chk({tag, "_rst_initdone"}, init_done, 0);
    chk({tag, "_rst_binvalid"}, bin_valid, 0);
    chk({tag, "_rst_overrun"}, overrun, 0);
    chk({tag, "_rst_addr"}, portb_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    while (!init_done && cyc < 1000) begin
      @(negedge clk);
      #1;
      if (portb_wren_bus === 32'hFFFF_FFFF) begin
        if (portb_addr !== 8'(wr)) seq++;
        wr++;
      end else if (portb_wren_bus !== 32'd0) begin
        bad++;
      end
      if (portb_rd_en !== 1'b0) bad++;
      cyc++;
    end
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_clr_cycles"}, wr, BINS);
    chk({tag, "_clr_addr_seq"}, seq, 0);
    chk({tag, "_clr_bad_bus"}, bad, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_ram_zero"}, mem_nz(), 0);
  endtask

  typedef struct {
    string name;
    int    stall;
    int    inj_bank;
    int    exp_beats;
    int    exp_sd;
    logic  exp_ovr;
  } row_t;

  row_t rows [3];

  task automatic run_frame(input row_t r);
    int   cyc = 0;
    int   beats = 0;
    int   ord_err = 0;
    int   stall_err = 0;
    int   ovl_err = 0;
    int   lat_err = 0;
    int   sd_cnt = 0;
    int   first_rd = -1;
    int   last_rd = -1;
    int   sd_cyc = -1;
    int   eb;
    int   ea;
    bit   done = 0;
    bit   inj = 0;
    int   q_iss [$];
    @(negedge clk);
    do_fill = 1'b1;
    @(negedge clk);
    do_fill = 1'b0;
    while (!done && cyc < 40000) begin
      if (cyc > 0) @(negedge clk);
      frame_done = (cyc == 0);
      if (cyc > 0 && !inj && r.inj_bank >= 0 &&
          int'(portb_bank_sel) == r.inj_bank) begin
        frame_done = 1'b1;
        inj = 1;
      end
      rd_ready = (r.stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (portb_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        q_iss.push_back(cyc);
        if (!rd_ready) stall_err++;
        if (portb_wren_bus !== 32'd0) ovl_err++;
      end
      if (bin_valid) begin
        if (q_iss.size() == 0) lat_err++;
        else if (cyc - q_iss.pop_front() != RD_LAT + 1) lat_err++;
        eb = beats / BINS;
        ea = beats % BINS;
        if (int'(bin_bank) != eb || int'(bin_addr) != ea ||
            bin_data !== 16'(eb * BINS + ea)) ord_err++;
        beats++;
      end
      if (sched_done) begin
        sd_cnt++;
        if (sd_cyc < 0) sd_cyc = cyc;
      end
      if (sd_cyc >= 0 && cyc >= sd_cyc + 300) done = 1;
      cyc++;
    end
    frame_done = 1'b0;
    rd_ready = 1'b0;
    chk({r.name, "_finished"}, done, 1);
    chk({r.name, "_beats"}, beats, r.exp_beats);
    chk({r.name, "_order"}, ord_err, 0);
    chk({r.name, "_rd_while_stalled"}, stall_err, 0);
    chk({r.name, "_rd_wr_overlap"}, ovl_err, 0);
    chk({r.name, "_latency"}, lat_err, 0);
    chk({r.name, "_sched_done_cnt"}, sd_cnt, r.exp_sd);
    chk({r.name, "_overrun"}, overrun, r.exp_ovr);
    chk({r.name, "_busy_end"}, busy, 0);
    chk({r.name, "_ram_zero"}, mem_nz(), 0);
    if (r.stall == 0) begin
      chk({r.name, "_first_rd"}, first_rd, 1);
      chk({r.name, "_last_rd"}, last_rd, TOTAL);
      chk({r.name, "_sched_cyc"}, sd_cyc, TOTAL + RD_LAT + 1 + BINS + 1);
    end
  endtask

  initial begin
    int cyc;
    bit hit;
    rows[0] = '{"nostall", 0, -1, TOTAL, 1, 1'b0};
    rows[1] = '{"rand50",  1, -1, TOTAL, 1, 1'b0};
    rows[2] = '{"ovr_b7",  0,  7, TOTAL, 1, 1'b1};

    rst_n = 1'b0;
    frame_done = 1'b0;
    rd_ready = 1'b0;
    do_fill = 1'b1;
    repeat (3) @(negedge clk);
    do_fill = 1'b0;
    init_check("init");

    for (int i = 0; i < 3; i++) run_frame(rows[i]);

    @(negedge clk);
    frame_done = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    cyc = 0;
    hit = 0;
    while (!hit && cyc < 20000) begin
      @(negedge clk);
      #1;
      if (portb_wren_bus === 32'hFFFF_FFFF && portb_addr == 8'd100 &&
          busy) hit = 1;
      cyc++;
    end
    chk("reach_clr_100", hit, 1);
    rst_n = 1'b0;
    rd_ready = 1'b0;
    init_check("rst_mid_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
